adder_seq_ctrl: RTL and testbench

//  Multi-precision add/subtract sequencer around one shared adder_32 instance.

---
 rtl/adder_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 32-bit adder is reused once per
// word, least-significant word first, with the carry chained through a register.

module adder_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {32'd0, cin};
endmodule

module adder_seq_ctrl #(
    parameter  int WORDS = 4,
    localparam int N     = WORDS * 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow
);
    // Handshake: a request is taken on a rising edge where start=1 and
    // ready=1; start while ready=0 is dropped, never queued. done is a
    // one-cycle pulse, and result/flags hold until the next accepted start.

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DONE_S = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          op_q;
    logic [31:0]   a_w   [WORDS];
    logic [31:0]   b_w   [WORDS];
    logic [31:0]   res_w [WORDS];

    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sum;
    logic        cout;

    // Subtraction is a + ~b + 1: the +1 is the initial carry loaded on accept.
    assign x = a_w[idx];
    assign y = b_w[idx] ^ {32{op_q}};

    adder_32 u_adder (
        .x    (x),
        .y    (y),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_q      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                a_w[i]   <= '0;
                b_w[i]   <= '0;
                res_w[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < WORDS; i++) begin
                            a_w[i] <= a[i*32 +: 32];
                            b_w[i] <= b[i*32 +: 32];
                        end
                        op_q      <= op_sub;
                        idx       <= '0;
                        carry     <= op_sub;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    res_w[idx] <= sum;
                    carry      <= cout;
                    if (idx == LAST_IDX) begin
                        // Flags come from the top word only.
                        carry_out <= cout;
                        overflow  <= (x[31] == y[31]) && (sum[31] != x[31]);
                        idx       <= '0;
                        state     <= DONE_S;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE_S);

    for (genvar g = 0; g < WORDS; g++) begin : g_result
        assign result[g*32 +: 32] = res_w[g];
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl (WORDS=4): directed corner cases plus randomized
// operations checked against a wide-integer reference model.

module tb_adder_seq_ctrl;
    localparam int WORDS = 4;
    localparam int N     = WORDS * 32;
    localparam int W     = N + 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {overflow, carry_out, result} per issued operation.
    logic [W-1:0] exp_q[$];

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on the full operands.
    function automatic logic [W-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input logic sub);
        logic [N:0]   full;
        logic [N-1:0] r;
        logic         c;
        logic         ov;
        if (sub) begin
            r  = ma - mb;
            c  = (ma >= mb);
            ov = (ma[N-1] != mb[N-1]) && (r[N-1] != ma[N-1]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb};
            r    = full[N-1:0];
            c    = full[N];
            ov   = (ma[N-1] == mb[N-1]) && (r[N-1] != ma[N-1]);
        end
        return {ov, c, r};
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = '1;
            1: v = N'($urandom_range(0, 9));
            2: v = {1'b0, {(N-1){1'b1}}};
            3: v = {1'b1, {(N-1){1'b0}}};
            default: ;
        endcase
        return v;
    endfunction

    // Driver: issue one operation, optionally hammer start during RUN/DONE.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tsub, input bit noise);
        int           n;
        bit           seen;
        logic [W-1:0] e;
        @(negedge clk);
        check("ready_idle", {128'd0, ready}, 129'd1);
        a      = ta;
        b      = tb;
        op_sub = tsub;
        start  = 1'b1;
        exp_q.push_back(model(ta, tb, tsub));
        @(posedge clk);
        #1;
        check("accept_busy", {128'd0, busy}, 129'd1);
        check("accept_flags_clr", {127'd0, carry_out, overflow}, 129'd0);
        start  = noise;
        a      = rand_word();
        b      = rand_word();
        op_sub = 1'($urandom_range(0, 1));
        n      = 0;
        seen   = 0;
        while (n < 20 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end else if (noise) begin
                a      = rand_word();
                b      = rand_word();
                op_sub = 1'($urandom_range(0, 1));
                start  = 1'b1;
            end
        end
        check("latency", N'(n), N'(WORDS));
        e = exp_q.pop_front();
        if (seen) begin
            check("result", {1'b0, result}, {1'b0, e[N-1:0]});
            check("carry_out", {128'd0, carry_out}, {128'd0, e[N]});
            check("overflow", {128'd0, overflow}, {128'd0, e[N+1]});
            check("done_ready_low", {127'd0, ready, busy}, 129'd0);
        end
        @(posedge clk);
        #1;
        check("done_one_pulse", {127'd0, done, busy}, 129'd0);
        check("ready_after", {128'd0, ready}, 129'd1);
        check("result_held", {1'b0, result}, {1'b0, e[N-1:0]});
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b1;
        op_sub = 1'b0;
        a      = rand_word();
        b      = rand_word();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {128'd0, ready}, 129'd1);
        check("rst_busy_done", {127'd0, busy, done}, 129'd0);
        check("rst_result", {1'b0, result}, 129'd0);
        check("rst_flags", {127'd0, carry_out, overflow}, 129'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Carry chain, wrap, signed overflow, subtraction both ways.
        run_op({32'h0, {96{1'b1}}}, 128'd1, 1'b0, 1'b0);
        run_op('1, 128'd1, 1'b0, 1'b0);
        run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
        run_op(128'd5, 128'd7, 1'b1, 1'b0);
        run_op(128'd7, 128'd5, 1'b1, 1'b0);

        // Start requests during RUN/DONE must be dropped.
        run_op(rand_word(), rand_word(), 1'b0, 1'b1);
        run_op(rand_word(), rand_word(), 1'b1, 1'b1);

        // Abort in the second RUN cycle.
        @(negedge clk);
        a      = '1;
        b      = '1;
        op_sub = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {128'd0, ready}, 129'd1);
        check("abort_busy_done", {127'd0, busy, done}, 129'd0);
        check("abort_result", {1'b0, result}, 129'd0);
        check("abort_flags", {127'd0, carry_out, overflow}, 129'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(128'd3, 128'd4, 1'b0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            run_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
        end

        check("queue_empty", N'(exp_q.size()), 129'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
